// File: rtl/ram_pkg.sv
// Shared helpers for the banked unaligned RAM: lane rotation and region decode.
package ram_pkg;

    localparam int NB_MAX    = 8;
    localparam int OFF_W_MAX = 3;
    localparam int XLEN_MAX  = 8 * NB_MAX;

    // Request byte order -> lane order: lane k carries byte (k - off) mod nb.
    function automatic logic [XLEN_MAX-1:0] lane_rot(
        input logic [XLEN_MAX-1:0]  data,
        input logic [OFF_W_MAX-1:0] off,
        input int                   nb
    );
        logic [XLEN_MAX-1:0] res;
        res = '0;
        for (int k = 0; k < NB_MAX; k++) begin
            if (k < nb) begin
                res[8*k +: 8] = data[8*((k - int'(off) + nb) % nb) +: 8];
            end
        end
        return res;
    endfunction

    // Lane order -> request byte order: byte j comes from lane (j + off) mod nb.
    function automatic logic [XLEN_MAX-1:0] lane_unrot(
        input logic [XLEN_MAX-1:0]  data,
        input logic [OFF_W_MAX-1:0] off,
        input int                   nb
    );
        logic [XLEN_MAX-1:0] res;
        res = '0;
        for (int j = 0; j < NB_MAX; j++) begin
            if (j < nb) begin
                res[8*j +: 8] = data[8*((j + int'(off)) % nb) +: 8];
            end
        end
        return res;
    endfunction

    // True when the top 'bits' bits of an xlen-wide address match the base.
    function automatic logic region_hit(
        input logic [XLEN_MAX-1:0] addr,
        input logic [XLEN_MAX-1:0] base,
        input int                  bits,
        input int                  xlen
    );
        logic hit;
        hit = 1'b1;
        for (int i = 0; i < XLEN_MAX; i++) begin
            if (i >= xlen - bits && i < xlen && addr[i] != base[i]) begin
                hit = 1'b0;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/ram_byte_bank.sv
// One byte-wide simple dual-port bank; the read output holds while not enabled.
module ram_byte_bank #(
    parameter int DEPTH = 16384,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [7:0]       i_din,
    input  logic             i_en,
    input  logic [IDX_W-1:0] i_raddr,
    output logic [7:0]       o_dout
);

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_dout;

    // Write port: commit the byte on the clock edge.
    always_ff @(posedge clk_i) begin
        if (i_we) r_mem[i_waddr] <= i_din;
    end

    // Read port: synchronous read, old data on a same-address write.
    always_ff @(posedge clk_i) begin
        if (i_en) r_dout <= r_mem[i_raddr];
    end

    assign o_dout = r_dout;

endmodule

// File: rtl/ram_unaligned_banked.sv
// Region-decoded byte-lane banked RAM with unaligned wrap-around access,
// write-first bypass and a registered valid/error read response.
module ram_unaligned_banked
    import ram_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              DEPTH       = 16384,
    parameter logic [XLEN-1:0] BASE_ADDR   = XLEN'(32'h1000_0000),
    parameter int              REGION_BITS = 8,
    parameter int              OUT_REG     = 0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              rd_req_i,
    input  logic [XLEN-1:0]   rd_addr_i,
    output logic              rd_valid_o,
    output logic [XLEN-1:0]   rd_data_o,
    output logic              rd_err_o,
    input  logic              wr_req_i,
    input  logic [XLEN-1:0]   wr_addr_i,
    input  logic [XLEN-1:0]   wr_data_i,
    input  logic [XLEN/8-1:0] wr_byte_en_i,
    output logic              wr_err_o
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);

    logic             w_rdHit, w_wrHit, w_rdEn;
    logic [IDX_W-1:0] w_rdWord, w_wrWord;
    logic [OFF_W-1:0] w_rdOff, w_wrOff;
    logic [IDX_W-1:0] w_rdIdx [NB];
    logic [IDX_W-1:0] w_wrIdx [NB];
    logic [NB-1:0]    w_wrLaneWe, w_byp;
    logic [XLEN-1:0]  w_wrLaneData, w_laneMerged, w_s1Data;
    logic [7:0]       w_bankDout [NB];

    logic             r_valid1, r_err1, r_hit1, r_wrErr;
    logic [OFF_W-1:0] r_off1;
    logic [NB-1:0]    r_byp1;
    logic [XLEN-1:0]  r_wbyte1;

    assign w_rdHit  = region_hit(64'(rd_addr_i), 64'(BASE_ADDR), REGION_BITS, XLEN);
    assign w_wrHit  = region_hit(64'(wr_addr_i), 64'(BASE_ADDR), REGION_BITS, XLEN);
    assign w_rdWord = rd_addr_i[OFF_W +: IDX_W];
    assign w_wrWord = wr_addr_i[OFF_W +: IDX_W];
    assign w_rdOff  = rd_addr_i[OFF_W-1:0];
    assign w_wrOff  = wr_addr_i[OFF_W-1:0];
    assign w_rdEn   = rd_req_i & w_rdHit;

    // Per-lane index, write enable, write byte and same-cycle bypass decision.
    always_comb begin
        logic [XLEN_MAX-1:0] rot;
        logic                we;
        w_rdIdx    = '{default: '0};
        w_wrIdx    = '{default: '0};
        w_wrLaneWe = '0;
        w_byp      = '0;
        rot          = lane_rot(64'(wr_data_i), OFF_W_MAX'(w_wrOff), NB);
        w_wrLaneData = rot[XLEN-1:0];
        for (int k = 0; k < NB; k++) begin
            w_rdIdx[k]    = w_rdWord + IDX_W'(OFF_W'(k) < w_rdOff);
            w_wrIdx[k]    = w_wrWord + IDX_W'(OFF_W'(k) < w_wrOff);
            we            = wr_req_i & w_wrHit & wr_byte_en_i[OFF_W'(OFF_W'(k) - w_wrOff)];
            w_wrLaneWe[k] = we;
            w_byp[k]      = we && (w_wrIdx[k] == w_rdIdx[k]);
        end
    end

    for (genvar k = 0; k < NB; k++) begin : g_lane
        ram_byte_bank #(
            .DEPTH (DEPTH),
            .IDX_W (IDX_W)
        ) u_bank (
            .clk_i   (clk_i),
            .i_we    (w_wrLaneWe[k]),
            .i_waddr (w_wrIdx[k]),
            .i_din   (w_wrLaneData[8*k +: 8]),
            .i_en    (w_rdEn),
            .i_raddr (w_rdIdx[k]),
            .o_dout  (w_bankDout[k])
        );
    end

    // First response stage: valid/error every cycle, request context held between requests.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_valid1 <= 1'b0;
            r_err1   <= 1'b0;
            r_hit1   <= 1'b0;
            r_off1   <= '0;
            r_byp1   <= '0;
            r_wbyte1 <= '0;
        end else begin
            r_valid1 <= rd_req_i;
            r_err1   <= rd_req_i & ~w_rdHit;
            if (rd_req_i) begin
                r_hit1   <= w_rdHit;
                r_off1   <= w_rdOff;
                r_byp1   <= w_byp & {NB{w_rdHit}};
                r_wbyte1 <= w_wrLaneData;
            end
        end
    end

    // Merge bypassed bytes over bank data, then rotate lanes back to request order.
    always_comb begin
        logic [XLEN_MAX-1:0] unrot;
        w_laneMerged = '0;
        for (int k = 0; k < NB; k++) begin
            w_laneMerged[8*k +: 8] = r_byp1[k] ? r_wbyte1[8*k +: 8] : w_bankDout[k];
        end
        unrot    = lane_unrot(64'(w_laneMerged), OFF_W_MAX'(r_off1), NB);
        w_s1Data = r_hit1 ? unrot[XLEN-1:0] : '0;
    end

    // Write miss flag, pulsed the cycle after the offending request.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_wrErr <= 1'b0;
        else          r_wrErr <= wr_req_i & ~w_wrHit;
    end

    assign wr_err_o = r_wrErr;

    if (OUT_REG != 0) begin : g_outReg
        logic            r_valid2, r_err2;
        logic [XLEN-1:0] r_data2;

        // Optional output register adding one cycle of read latency.
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                r_valid2 <= 1'b0;
                r_err2   <= 1'b0;
                r_data2  <= '0;
            end else begin
                r_valid2 <= r_valid1;
                r_err2   <= r_err1;
                if (r_valid1) r_data2 <= w_s1Data;
            end
        end

        assign rd_valid_o = r_valid2;
        assign rd_err_o   = r_err2;
        assign rd_data_o  = r_data2;
    end else begin : g_noOutReg
        assign rd_valid_o = r_valid1;
        assign rd_err_o   = r_err1;
        assign rd_data_o  = w_s1Data;
    end

endmodule

// File: tb/tb_ram_unaligned_banked.sv
// Directed self-checking bench: a 32-bit DEPTH=16 instance (latency 1) and a
// 64-bit DEPTH=16 instance with the output register (latency 2).
module tb_ram_unaligned_banked;

    logic clk_i = 1'b0;
    logic rst_n_i = 1'b0;

    logic        rdReq32 = 1'b0, wrReq32 = 1'b0;
    logic [31:0] rdAddr32 = '0, wrAddr32 = '0, wrData32 = '0;
    logic [3:0]  wrBe32 = '0;
    logic        rdValid32, rdErr32, wrErr32;
    logic [31:0] rdData32;

    logic        rdReq64 = 1'b0, wrReq64 = 1'b0;
    logic [63:0] rdAddr64 = '0, wrAddr64 = '0, wrData64 = '0;
    logic [7:0]  wrBe64 = '0;
    logic        rdValid64, rdErr64, wrErr64;
    logic [63:0] rdData64;

    int nCompared = 0;
    int nMismatched = 0;

    localparam logic [63:0] BASE64 = 64'h1000_0000_0000_0000;

    always #5 clk_i = ~clk_i;

    ram_unaligned_banked #(
        .XLEN(32), .DEPTH(16), .BASE_ADDR(32'h1000_0000), .REGION_BITS(8), .OUT_REG(0)
    ) dut32 (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .rd_req_i(rdReq32), .rd_addr_i(rdAddr32),
        .rd_valid_o(rdValid32), .rd_data_o(rdData32), .rd_err_o(rdErr32),
        .wr_req_i(wrReq32), .wr_addr_i(wrAddr32), .wr_data_i(wrData32),
        .wr_byte_en_i(wrBe32), .wr_err_o(wrErr32)
    );

    ram_unaligned_banked #(
        .XLEN(64), .DEPTH(16), .BASE_ADDR(BASE64), .REGION_BITS(8), .OUT_REG(1)
    ) dut64 (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .rd_req_i(rdReq64), .rd_addr_i(rdAddr64),
        .rd_valid_o(rdValid64), .rd_data_o(rdData64), .rd_err_o(rdErr64),
        .wr_req_i(wrReq64), .wr_addr_i(wrAddr64), .wr_data_i(wrData64),
        .wr_byte_en_i(wrBe64), .wr_err_o(wrErr64)
    );

    // Advance one clock; inputs set beforehand are sampled at this edge.
    task automatic applyStimulus();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic write32(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        wrReq32 = 1'b1; wrAddr32 = addr; wrData32 = data; wrBe32 = be;
        applyStimulus();
        wrReq32 = 1'b0;
    endtask

    task automatic write64(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] be);
        wrReq64 = 1'b1; wrAddr64 = addr; wrData64 = data; wrBe64 = be;
        applyStimulus();
        wrReq64 = 1'b0;
    endtask

    // Read with latency 1, then confirm the pulse ends and the data holds.
    task automatic read32(input string tag, input logic [31:0] addr, input logic [31:0] expData, input logic expErr);
        rdReq32 = 1'b1; rdAddr32 = addr;
        applyStimulus();
        rdReq32 = 1'b0;
        checkOutput({tag, "_valid"}, 64'(rdValid32), 64'(1'b1));
        checkOutput({tag, "_err"}, 64'(rdErr32), 64'(expErr));
        checkOutput({tag, "_data"}, 64'(rdData32), 64'(expData));
        applyStimulus();
        checkOutput({tag, "_validLow"}, 64'(rdValid32), 64'(1'b0));
        checkOutput({tag, "_hold"}, 64'(rdData32), 64'(expData));
    endtask

    initial begin
        $display("[TB] start");
        applyStimulus();
        applyStimulus();
        checkOutput("rst32_valid", 64'(rdValid32), 64'd0);
        checkOutput("rst32_err", 64'(rdErr32), 64'd0);
        checkOutput("rst32_data", 64'(rdData32), 64'd0);
        checkOutput("rst32_wrErr", 64'(wrErr32), 64'd0);
        checkOutput("rst64_valid", 64'(rdValid64), 64'd0);
        checkOutput("rst64_data", rdData64, 64'd0);
        rst_n_i = 1'b1;
        applyStimulus();

        // Clear all 16 words of the small 32-bit instance.
        for (int i = 0; i < 16; i++) write32(32'h1000_0000 + 32'(i * 4), 32'h0, 4'hF);

        // Aligned write then read.
        write32(32'h1000_0000, 32'hDEAD_BEEF, 4'hF);
        checkOutput("aligned_wrErr", 64'(wrErr32), 64'd0);
        read32("aligned", 32'h1000_0000, 32'hDEAD_BEEF, 1'b0);

        // Unaligned write straddling words 0 and 1.
        write32(32'h1000_0003, 32'h1122_3344, 4'hF);
        read32("unal_w0", 32'h1000_0000, 32'h44AD_BEEF, 1'b0);
        read32("unal_w1", 32'h1000_0004, 32'h0011_2233, 1'b0);
        read32("unal_a3", 32'h1000_0003, 32'h1122_3344, 1'b0);

        // Write at the top word wraps the upper bytes into word 0.
        write32(32'h1000_003E, 32'hAABB_CCDD, 4'hF);
        read32("wrap_w0", 32'h1000_0000, 32'h44AD_AABB, 1'b0);
        read32("wrap_top", 32'h1000_003E, 32'hAABB_CCDD, 1'b0);

        // Region misses.
        read32("miss_rd", 32'h2000_0000, 32'h0, 1'b1);
        write32(32'h2000_0000, 32'hFFFF_FFFF, 4'hF);
        checkOutput("miss_wrErr", 64'(wrErr32), 64'd1);
        applyStimulus();
        checkOutput("miss_wrErrLow", 64'(wrErr32), 64'd0);
        read32("miss_noChange", 32'h1000_0000, 32'h44AD_AABB, 1'b0);

        // Zero byte enables on a hit: nothing written, no error.
        write32(32'h1000_0000, 32'h1234_5678, 4'h0);
        checkOutput("be0_wrErr", 64'(wrErr32), 64'd0);
        read32("be0_noChange", 32'h1000_0000, 32'h44AD_AABB, 1'b0);

        // Same-cycle read and write: write-first bypass on enabled bytes.
        wrReq32 = 1'b1; wrAddr32 = 32'h1000_0008; wrData32 = 32'h5566_7788; wrBe32 = 4'b0101;
        rdReq32 = 1'b1; rdAddr32 = 32'h1000_0008;
        applyStimulus();
        wrReq32 = 1'b0; rdReq32 = 1'b0;
        checkOutput("byp_valid", 64'(rdValid32), 64'd1);
        checkOutput("byp_data", 64'(rdData32), 64'h0066_0088);
        read32("byp_after", 32'h1000_0008, 32'h0066_0088, 1'b0);

        // Unaligned bypass across a word boundary.
        wrReq32 = 1'b1; wrAddr32 = 32'h1000_000A; wrData32 = 32'h0000_00A5; wrBe32 = 4'b0001;
        rdReq32 = 1'b1; rdAddr32 = 32'h1000_0009;
        applyStimulus();
        wrReq32 = 1'b0; rdReq32 = 1'b0;
        checkOutput("bypU_data", 64'(rdData32), 64'h0000_A500);

        // 64-bit instance: clear, then load two words.
        for (int i = 0; i < 4; i++) write64(BASE64 + 64'(i * 8), 64'h0, 8'hFF);
        write64(BASE64, 64'h0706_0504_0302_0100, 8'hFF);
        write64(BASE64 + 64'd8, 64'h0F0E_0D0C_0B0A_0908, 8'hFF);

        // Back-to-back reads with latency 2.
        rdReq64 = 1'b1; rdAddr64 = BASE64;
        applyStimulus();
        checkOutput("b2b_p1_valid", 64'(rdValid64), 64'd0);
        rdAddr64 = BASE64 + 64'd8;
        applyStimulus();
        checkOutput("b2b_p2_valid", 64'(rdValid64), 64'd1);
        checkOutput("b2b_p2_data", rdData64, 64'h0706_0504_0302_0100);
        rdAddr64 = BASE64 + 64'd3;
        applyStimulus();
        rdReq64 = 1'b0;
        checkOutput("b2b_p3_valid", 64'(rdValid64), 64'd1);
        checkOutput("b2b_p3_data", rdData64, 64'h0F0E_0D0C_0B0A_0908);
        applyStimulus();
        checkOutput("b2b_p4_valid", 64'(rdValid64), 64'd1);
        checkOutput("b2b_p4_err", 64'(rdErr64), 64'd0);
        checkOutput("b2b_p4_data", rdData64, 64'h0A09_0807_0605_0403);
        applyStimulus();
        checkOutput("b2b_p5_valid", 64'(rdValid64), 64'd0);
        checkOutput("b2b_p5_hold", rdData64, 64'h0A09_0807_0605_0403);

        // Reset after the second request of a burst drops everything in flight.
        rdReq64 = 1'b1; rdAddr64 = BASE64;
        applyStimulus();
        rdAddr64 = BASE64 + 64'd8;
        applyStimulus();
        rdReq64 = 1'b0;
        rst_n_i = 1'b0;
        #1;
        checkOutput("rstMid_valid", 64'(rdValid64), 64'd0);
        checkOutput("rstMid_err", 64'(rdErr64), 64'd0);
        checkOutput("rstMid_data", rdData64, 64'd0);
        checkOutput("rstMid_wrErr", 64'(wrErr64), 64'd0);
        checkOutput("rstMid_data32", 64'(rdData32), 64'd0);
        applyStimulus();
        checkOutput("rstHold_valid", 64'(rdValid64), 64'd0);
        rst_n_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("postRst_valid", 64'(rdValid64), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/ram_unaligned_banked.md
Name: ram_unaligned_banked

Overview:
- Parametrised successor to the fixed 32-bit IRAM/DRAM unaligned-access memory.
- One region-decoded memory built from NB = XLEN/8 inferred byte-lane banks.
- Full unaligned read/write support with wrap-around at the top of the region.
- Registered read-valid/error handshake replaces tri-state sharing; write-first bypass for same-cycle read/write overlap; optional output register. Instantiated once per region (instruction, data) in the SoC.

Parameters:
- XLEN, 32, data/address width; legal values 32 or 64; NB = XLEN/8 lanes, OFF_W = log2(NB).
- DEPTH, 16384, words per region (power of two); IDX_W = log2(DEPTH).
- BASE_ADDR, 32'h1000_0000, region base; only the top REGION_BITS bits are compared.
- REGION_BITS, 8, width of the region decode slice addr[XLEN-1 -: REGION_BITS].
- OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- rd_req_i  in  1  read request, one per cycle, no backpressure.
- rd_addr_i  in  XLEN  byte address, any alignment.
- rd_valid_o  out  1  read response valid, one-cycle pulse per request.
- rd_data_o  out  XLEN  read data, little-endian, byte 0 at rd_addr.
- rd_err_o  out  1  qualifies rd_valid_o; 1 = region miss.
- wr_req_i  in  1  write request.
- wr_addr_i  in  XLEN  byte address, any alignment.
- wr_data_i  in  XLEN  write data, byte 0 to wr_addr.
- wr_byte_en_i  in  NB  per-byte enable, relative to wr_addr.
- wr_err_o  out  1  registered pulse, one cycle after a write region miss.

Behaviour:
- Reset: rd_valid_o=0, rd_err_o=0, rd_data_o=0, wr_err_o=0; all pipeline valid bits cleared, so requests in flight are dropped with no response. Memory contents are not reset.
- Hit: addr slice == BASE_ADDR slice. Word index w = addr[OFF_W +: IDX_W]; offset o = addr[OFF_W-1:0].
- Lane mapping: lane k uses index (w + (k < o)) mod DEPTH, so the top word wraps to word 0. Lane k carries request byte j = (k - o) mod NB; write enable is wr_byte_en_i[j].
- Write:
  - Committed at the posedge where wr_req_i=1 and the address hits.
  - Miss: no memory change, and wr_err_o=1 on the next cycle.
  - Byte enables all zero with a hit: no-op, no error.
- Read:
  - Bank read is synchronous. Rotation uses the registered offset: data byte j = lane (j + o_r1) mod NB.
  - rd_valid_o asserts exactly 1+OUT_REG cycles after rd_req_i.
  - Hit: rd_err_o=0 with data. Miss: rd_err_o=1 and rd_data_o=0.
  - Fully pipelined: back-to-back requests give back-to-back valids.
  - With no response, rd_valid_o=0 and rd_data_o holds its last value.
- Simultaneous read and write in the same cycle: per lane, if both hit the same lane index and the write enable is set, the read returns the new byte (write-first bypass). The bypass decision and write byte are registered alongside the read.
- Read and write decode independently; reads never stall writes.

Decomposition:
- ram_pkg holds:
  - function lane_rot(data, off) and its inverse;
  - function region_hit(addr, base, bits);
  - constants NB_MAX = 8, OFF_W_MAX = 3.
- Sub-module ram_byte_bank: one simple dual-port DEPTH x 8 array with write port (we, addr, din) and registered read (en, addr, dout). Instantiated NB times in a generate loop.
- Top level: lane address/data/enable steering, bypass compare, response pipeline.

Test Plan:
- Aligned access, XLEN=32: write 0x1000_0000 <- 0xDEADBEEF, be=4'hF; read 0x1000_0000 -> rd_valid 1 cycle later, data 0xDEADBEEF, err 0.
- Unaligned access: write 0x1000_0003 <- 0x11223344, be=4'hF; read 0x1000_0000 -> 0x44xxxxxx (byte 3 = 0x44); read 0x1000_0004 -> 0xxx112233; read 0x1000_0003 -> 0x11223344.
- Wrap-around, DEPTH=16: write 0x1000_003E <- 0xAABBCCDD; read 0x1000_0000 -> low half 0xAABB; read 0x1000_003E -> 0xAABBCCDD.
- Region miss: read 0x2000_0000 -> rd_valid=1, rd_err=1, data 0. Write 0x2000_0000 -> wr_err pulses 1 cycle; a re-read at 0x1000_0000 shows no change.
- Same-cycle read and write at 0x1000_0008: write 0x55667788 with be=4'b0101 over prior 0x00000000 -> read returns 0x00660088.
- OUT_REG=1, XLEN=64: three back-to-back reads give valids on cycles +2, +3, +4. Assert rst_n_i low after the second request -> no further rd_valid; all outputs read 0 during reset.
